// File: rtl/mux4x1_scan_ctrl_if.sv
// mux4x1_scan_ctrl_if: control, mux-select and capture signals of the 4:1 mux scan controller
interface mux4x1_scan_ctrl_if;
  logic       start;
  logic       stop;
  logic [3:0] ch_en;
  logic       y;
  logic       s1;
  logic       s2;
  logic       busy;
  logic       sample_valid;
  logic [1:0] sample_ch;
  logic       sample_bit;
  logic [3:0] frame;
  logic       frame_valid;
  modport master (
    output start, stop, ch_en, y,
    input  s1, s2, busy, sample_valid, sample_ch, sample_bit, frame, frame_valid
  );
  modport slave (
    input  start, stop, ch_en, y,
    output s1, s2, busy, sample_valid, sample_ch, sample_bit, frame, frame_valid
  );
endinterface

// File: rtl/mux4x1_scan_ctrl.sv
// mux4x1_scan_ctrl: round-robin dwell scan of a 4:1 mux with per-channel capture and frame assembly
module mux4x1_scan_ctrl #(
  parameter int DWELL  = 4,
  parameter int SETTLE = 1
) (
  input logic               clk,
  input logic               rst_n,
  mux4x1_scan_ctrl_if.slave bus
);
  typedef enum logic {IDLE, SCAN} state_e;
  localparam logic [7:0] LAST = 8'(DWELL - 1);
  localparam logic [7:0] CAP  = 8'(SETTLE);
  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d, sample_ch_q, sample_ch_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d, acc_q, acc_d, frame_q, frame_d, above;
  logic       busy_q, busy_d, stop_q, stop_d;
  logic       sample_valid_q, sample_valid_d, sample_bit_q, sample_bit_d;
  logic       frame_valid_q, frame_valid_d;
  function automatic logic [1:0] lowest(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  assign above = mask_q & (4'b1110 << sel_q);
  // capture may land on the dwell's last cycle, so the frame is built from acc_d
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    busy_d         = busy_q;
    mask_d         = mask_q;
    stop_d         = stop_q;
    acc_d          = acc_q;
    frame_d        = frame_q;
    frame_valid_d  = 1'b0;
    sample_valid_d = 1'b0;
    sample_ch_d    = sample_ch_q;
    sample_bit_d   = sample_bit_q;
    if (state_q == IDLE) begin
      if (bus.start && bus.ch_en != 4'd0) begin
        state_d = SCAN;
        mask_d  = bus.ch_en;
        sel_d   = lowest(bus.ch_en);
        cnt_d   = '0;
        busy_d  = 1'b1;
        acc_d   = '0;
      end
    end else begin
      cnt_d  = cnt_q + 8'd1;
      stop_d = stop_q | bus.stop;
      if (cnt_q == CAP) begin
        sample_valid_d = 1'b1;
        sample_ch_d    = sel_q;
        sample_bit_d   = bus.y;
        acc_d[sel_q]   = bus.y;
      end
      if (cnt_q == LAST) begin
        cnt_d = '0;
        sel_d = lowest(above);
        if (above == 4'd0) begin
          frame_d       = acc_d & mask_q;
          frame_valid_d = 1'b1;
          mask_d        = bus.ch_en;
          acc_d         = '0;
          sel_d         = lowest(bus.ch_en);
          if (stop_d || bus.ch_en == 4'd0) begin
            state_d = IDLE;
            sel_d   = 2'd0;
            busy_d  = 1'b0;
            stop_d  = 1'b0;
          end
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      cnt_q          <= '0;
      busy_q         <= 1'b0;
      mask_q         <= '0;
      stop_q         <= 1'b0;
      acc_q          <= '0;
      frame_q        <= '0;
      frame_valid_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_ch_q    <= '0;
      sample_bit_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      cnt_q          <= cnt_d;
      busy_q         <= busy_d;
      mask_q         <= mask_d;
      stop_q         <= stop_d;
      acc_q          <= acc_d;
      frame_q        <= frame_d;
      frame_valid_q  <= frame_valid_d;
      sample_valid_q <= sample_valid_d;
      sample_ch_q    <= sample_ch_d;
      sample_bit_q   <= sample_bit_d;
    end
  end
  assign bus.s1           = sel_q[1];
  assign bus.s2           = sel_q[0];
  assign bus.busy         = busy_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_ch    = sample_ch_q;
  assign bus.sample_bit   = sample_bit_q;
  assign bus.frame        = frame_q;
  assign bus.frame_valid  = frame_valid_q;
endmodule

// File: tb/tb_mux4x1_scan_ctrl.sv
// tb_mux4x1_scan_ctrl: directed scan scenarios with sample/frame scoreboard queues
module tb_mux4x1_scan_ctrl;
  localparam int DWELL = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] mux_in = 4'd0;
  int         tests = 0;
  int         fails = 0;
  logic [2:0] sq[$];
  logic [3:0] fq[$];
  mux4x1_scan_ctrl_if bus ();
  mux4x1_scan_ctrl #(.DWELL(DWELL), .SETTLE(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  assign bus.y = mux_in[{bus.s1, bus.s2}];
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [11:0] outs();
    return {bus.s1, bus.s2, bus.busy, bus.sample_valid, bus.sample_ch, bus.sample_bit, bus.frame, bus.frame_valid};
  endfunction
  function automatic logic [1:0] sel();
    return {bus.s1, bus.s2};
  endfunction
  task automatic push_frame(input logic [3:0] en, input logic [3:0] m);
    for (int ch = 0; ch < 4; ch++) if (en[ch]) sq.push_back({2'(ch), m[ch]});
    fq.push_back(m & en);
  endtask
  task automatic tick();
    logic [2:0] s;
    @(posedge clk);
    #1;
    if (bus.sample_valid) begin
      check("sample_expected", sq.size() != 0, 1);
      if (sq.size() != 0) begin
        s = sq.pop_front();
        check("sample_ch", bus.sample_ch, s[2:1]);
        check("sample_bit", bus.sample_bit, s[0]);
      end
    end
    if (bus.frame_valid) begin
      check("frame_expected", fq.size() != 0, 1);
      if (fq.size() != 0) check("frame", bus.frame, fq.pop_front());
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.ch_en = 4'd0;
    #2 rst_n = 1'b0;
    #1 check("reset_outs", outs(), 12'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("idle_outs", outs(), 12'd0);
    // a-only data, full mask, stop during channel 1
    mux_in = 4'b0001;
    bus.ch_en = 4'b1111;
    push_frame(4'b1111, mux_in);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t1_busy", bus.busy, 1);
    check("t1_sel0", sel(), 0);
    for (int i = 1; i <= 16; i++) begin
      bus.stop = (i == 6);
      tick();
      check("t1_sel", sel(), i < 16 ? i / 4 : 0);
      check("t1_fv", bus.frame_valid, i == 16);
      check("t1_busy", bus.busy, i < 16);
    end
    bus.stop = 1'b0;
    repeat (3) tick();
    check("t1_idle", bus.busy, 0);
    // alternating a/c, three frames, stop in the third
    mux_in = 4'b1110;
    bus.ch_en = 4'b0101;
    repeat (3) push_frame(4'b0101, mux_in);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      bus.stop = (i == 18);
      tick();
      check("t2_sel", sel(), (i % 8) >= 4 ? 2 : 0);
      check("t2_fv", bus.frame_valid, (i % 8) == 0);
      check("t2_busy", bus.busy, i < 24);
    end
    bus.stop = 1'b0;
    // empty mask start is ignored
    bus.ch_en = 4'b0000;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_outs", {bus.busy, bus.s1, bus.s2, bus.sample_valid, bus.frame_valid}, 0);
    end
    // mask shrinks to d mid-frame
    mux_in = 4'b1000;
    bus.ch_en = 4'b1111;
    push_frame(4'b1111, mux_in);
    repeat (2) push_frame(4'b1000, mux_in);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (i == 5) bus.ch_en = 4'b1000;
      bus.stop = (i == 22);
      tick();
      check("t5_sel", sel(), i < 16 ? i / 4 : i < 24 ? 3 : 0);
      check("t5_fv", bus.frame_valid, i == 16 || i == 20 || i == 24);
      check("t5_busy", bus.busy, i < 24);
    end
    bus.stop = 1'b0;
    // asynchronous reset mid-scan
    mux_in = 4'b0001;
    bus.ch_en = 4'b1111;
    push_frame(4'b1111, mux_in);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    check("t6_busy_pre", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1 check("t6_async_outs", outs(), 12'd0);
    sq.delete();
    fq.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t6_idle", {bus.busy, bus.s1, bus.s2, bus.sample_valid, bus.frame_valid}, 0);
    end
    check("sq_drained", sq.size(), 0);
    check("fq_drained", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mux4x1_scan_ctrl.md
Name: mux4x1_scan_ctrl

Overview:
Round-robin time-division scan controller for the 4:1 gate-level mux. Drives the mux select lines s1/s2 through the enabled channels and holds each channel for a fixed dwell time. Captures the mux output y once per channel after a settling delay. Assembles the four captured bits into a frame word for downstream logic.

Parameters:
DWELL, 4, cycles each channel is held selected; legal range 2..255.
SETTLE, 1, cycles after a select change before y is sampled; legal range 1..DWELL-1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin scanning
stop  in  1  request to halt; honoured at the next frame boundary
ch_en  in  4  channel enable mask; bit0=a, bit1=b, bit2=c, bit3=d
y  in  1  output of the 4:1 mux
s1  out  1  select MSB to the mux
s2  out  1  select LSB to the mux
busy  out  1  high while scanning
sample_valid  out  1  one-cycle pulse when sample_bit/sample_ch are valid
sample_ch  out  2  channel index of the current sample
sample_bit  out  1  captured y value
frame  out  4  captured bits by channel index; disabled channels read 0
frame_valid  out  1  one-cycle pulse when frame is updated

Behaviour:
- Select encoding is fixed: {s1,s2}=00 selects a, 01 selects b, 10 selects c, 11 selects d. s1/s2 are registered outputs.
- Reset (asynchronous, takes effect immediately, including mid-scan): state IDLE; s1=s2=0, busy=0, sample_valid=0, sample_ch=0, sample_bit=0, frame=0, frame_valid=0; internal mask, dwell counter, stop flag and frame accumulator are cleared.
- States: IDLE, SCAN.
- IDLE -> SCAN: start=1 and ch_en!=0. ch_en is latched into an internal mask. The select moves to the lowest enabled channel. The dwell counter is set to 0, busy=1, and the accumulator is cleared. All of this is visible in the next cycle. start with ch_en=0 is ignored.
- start while in SCAN is ignored.
- SCAN: the dwell counter increments every cycle from 0 to DWELL-1.
  - When the counter equals SETTLE, y is captured at that clock edge.
  - In the following cycle, sample_valid=1, sample_ch=the current channel, sample_bit=the captured y. The captured bit is also written into the accumulator at the channel index.
  - When the counter equals DWELL-1, the counter returns to 0 and the select advances to the next higher enabled channel.
- Frame boundary: the cycle in which the counter equals DWELL-1 on the highest enabled channel.
  - At that edge, frame is loaded from the accumulator with disabled bits forced to 0. frame_valid pulses in the next cycle. frame holds its value until the next frame_valid.
  - At that edge, ch_en is re-latched.
  - If the stop flag is set, or the new mask is 0: go to IDLE, with s1=s2=0 and busy=0 in the same cycle as frame_valid.
  - Otherwise: select the lowest enabled channel of the new mask and clear the accumulator.
- stop: a one-cycle pulse sets a sticky flag. The flag is cleared when the block enters IDLE. stop in IDLE has no effect.
- ch_en changes during a frame have no effect until the next frame boundary.
- With a single enabled channel, a frame completes every DWELL cycles and the select never changes.
- Steady-state frame period is DWELL × popcount(mask) cycles. The first frame_valid occurs DWELL × popcount + 1 cycles after the start edge.
- sample_valid and frame_valid may be high in the same cycle.

Test Plan:
- Reset, then DWELL=4, SETTLE=1, ch_en=1111, start pulse; mux inputs a=1, b=0, c=0, d=0 -> select sequence 00, 01, 10, 11 at 4 cycles each; sample_valid pulses with sample_ch 0, 1, 2, 3 and sample_bit 1, 0, 0, 0; frame_valid occurs 17 cycles after start with frame=0001.
- Mux inputs a=0, b=1, c=1, d=1, ch_en=0101, continuous scan -> selects alternate 00/10; frame=0100; frame_valid every 8 cycles; bits 1 and 3 read 0.
- start with ch_en=0000 -> busy stays 0, s1=s2=0, and no pulses occur.
- stop pulsed during channel 1 of a 1111 scan -> channels 2 and 3 still complete, frame_valid pulses, busy falls in the same cycle, and selects return to 00.
- ch_en changed from 1111 to 1000 mid-frame -> the current frame completes with all 4 channels; the next frame scans only d, with frame_valid every 4 cycles.
- rst_n asserted low mid-scan, asynchronously between clock edges -> all outputs 0 immediately; after release the block stays in IDLE until the next start.
